bus_slave_router: RTL and testbench

Downstream stage of the 2-master arbiter. Accepts the single arbitrated request (enable, write, data, address, byte enables, atomic flag, master id), decodes the address to one of two slaves (main memory, peripheral block), and holds the request until that slave acks. Returns one-cycle ack plus read data upstream. Unmapped addresses and slaves that never ack return an error response instead of hanging the bus.

---
 rtl/bus_slave_router_if.sv | 45 ++++
 rtl/bus_slave_router.sv | 133 +++++++++++++
 tb/tb_bus_slave_router.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/bus_slave_router_if.sv
// rtl/bus_slave_router_if.sv - upstream request/response and two-slave bus bundle for bus_slave_router
interface bus_slave_router_if;
  logic        i_bus_en;
  logic        i_wr_en;
  logic [31:0] i_wr_data;
  logic [31:0] i_addr;
  logic [3:0]  i_byte_en;
  logic        i_atomic;
  logic        i_id;
  logic        o_ack;
  logic [31:0] o_rd_data;
  logic        o_err;
  logic        o_atomic;
  logic        o_id;
  logic        o_s0_en;
  logic        o_s0_wr_en;
  logic [31:0] o_s0_wr_data;
  logic [31:0] o_s0_addr;
  logic [3:0]  o_s0_byte_en;
  logic        i_s0_ack;
  logic [31:0] i_s0_rd_data;
  logic        o_s1_en;
  logic        o_s1_wr_en;
  logic [31:0] o_s1_wr_data;
  logic [31:0] o_s1_addr;
  logic [3:0]  o_s1_byte_en;
  logic        i_s1_ack;
  logic [31:0] i_s1_rd_data;

  modport slave (
    input  i_bus_en, i_wr_en, i_wr_data, i_addr, i_byte_en, i_atomic, i_id,
    input  i_s0_ack, i_s0_rd_data, i_s1_ack, i_s1_rd_data,
    output o_ack, o_rd_data, o_err, o_atomic, o_id,
    output o_s0_en, o_s0_wr_en, o_s0_wr_data, o_s0_addr, o_s0_byte_en,
    output o_s1_en, o_s1_wr_en, o_s1_wr_data, o_s1_addr, o_s1_byte_en
  );

  modport master (
    output i_bus_en, i_wr_en, i_wr_data, i_addr, i_byte_en, i_atomic, i_id,
    output i_s0_ack, i_s0_rd_data, i_s1_ack, i_s1_rd_data,
    input  o_ack, o_rd_data, o_err, o_atomic, o_id,
    input  o_s0_en, o_s0_wr_en, o_s0_wr_data, o_s0_addr, o_s0_byte_en,
    input  o_s1_en, o_s1_wr_en, o_s1_wr_data, o_s1_addr, o_s1_byte_en
  );
endinterface

// File: rtl/bus_slave_router.sv
// rtl/bus_slave_router.sv - decodes one arbitrated request to memory or peripheral slave
// and returns a single-cycle ack, with error response for unmapped addresses and timeouts.
module bus_slave_router #(
  parameter logic [31:0] MEM_BASE = 32'h0000_0000,
  parameter logic [31:0] MEM_MASK = 32'hFFFF_0000,
  parameter logic [31:0] PER_BASE = 32'h8000_0000,
  parameter logic [31:0] PER_MASK = 32'hFFFF_F000,
  parameter int          TIMEOUT  = 16
) (
  input logic                 i_clk,
  input logic                 i_rst,
  bus_slave_router_if.slave   bus
);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, GAP} state_t;

  typedef struct packed {
    logic        en;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] addr;
    logic [3:0]  byte_en;
  } slv_req_t;

  state_t        state_q;
  logic          sel_q;
  logic          wr_q;
  logic [CW-1:0] cnt_q;
  logic          ack_q;
  logic          err_q;
  logic [31:0]   rd_data_q;
  logic          atomic_q;
  logic          id_q;
  slv_req_t      s0_q;
  slv_req_t      s1_q;

  logic          mem_hit;
  logic          per_hit;
  logic          sel_ack;
  logic [31:0]   sel_rd_data;
  slv_req_t      req_in;

  assign mem_hit     = (bus.i_addr & MEM_MASK) == MEM_BASE;
  assign per_hit     = (bus.i_addr & PER_MASK) == PER_BASE;
  assign sel_ack     = sel_q ? bus.i_s1_ack : bus.i_s0_ack;
  assign sel_rd_data = sel_q ? bus.i_s1_rd_data : bus.i_s0_rd_data;
  assign req_in      = '{en: 1'b1, wr_en: bus.i_wr_en, wr_data: bus.i_wr_data,
                         addr: bus.i_addr, byte_en: bus.i_byte_en};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      wr_q      <= 1'b0;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      atomic_q  <= 1'b0;
      id_q      <= 1'b0;
      s0_q      <= '0;
      s1_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_bus_en) begin
            wr_q  <= bus.i_wr_en;
            cnt_q <= '0;
            // Memory is checked first so it wins any overlap with the peripheral window.
            if (mem_hit) begin
              sel_q    <= 1'b0;
              s0_q     <= req_in;
              atomic_q <= bus.i_atomic;
              id_q     <= bus.i_id;
              state_q  <= ACCESS;
            end else if (per_hit) begin
              sel_q    <= 1'b1;
              s1_q     <= req_in;
              atomic_q <= bus.i_atomic;
              id_q     <= bus.i_id;
              state_q  <= ACCESS;
            end else begin
              ack_q     <= 1'b1;
              err_q     <= 1'b1;
              rd_data_q <= '0;
              state_q   <= RESP;
            end
          end
        end
        ACCESS: begin
          // A slave ack on the final counted cycle still beats the timeout.
          if (sel_ack || cnt_q == CW'(TIMEOUT)) begin
            ack_q     <= 1'b1;
            err_q     <= !sel_ack;
            rd_data_q <= (sel_ack && !wr_q) ? sel_rd_data : '0;
            s0_q      <= '0;
            s1_q      <= '0;
            atomic_q  <= 1'b0;
            id_q      <= 1'b0;
            state_q   <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          ack_q     <= 1'b0;
          err_q     <= 1'b0;
          rd_data_q <= '0;
          state_q   <= GAP;
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_ack        = ack_q;
  assign bus.o_err        = err_q;
  assign bus.o_rd_data    = rd_data_q;
  assign bus.o_atomic     = atomic_q;
  assign bus.o_id         = id_q;
  assign bus.o_s0_en      = s0_q.en;
  assign bus.o_s0_wr_en   = s0_q.wr_en;
  assign bus.o_s0_wr_data = s0_q.wr_data;
  assign bus.o_s0_addr    = s0_q.addr;
  assign bus.o_s0_byte_en = s0_q.byte_en;
  assign bus.o_s1_en      = s1_q.en;
  assign bus.o_s1_wr_en   = s1_q.wr_en;
  assign bus.o_s1_wr_data = s1_q.wr_data;
  assign bus.o_s1_addr    = s1_q.addr;
  assign bus.o_s1_byte_en = s1_q.byte_en;
endmodule

// File: tb/tb_bus_slave_router.sv
// tb/tb_bus_slave_router.sv - scoreboard testbench for bus_slave_router
module tb_bus_slave_router;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          at_edge;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  bus_slave_router_if bus ();

  bus_slave_router #(.TIMEOUT(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_zero(input string name);
    chk({name, "_ctl"}, 64'({bus.o_ack, bus.o_err, bus.o_atomic, bus.o_id, bus.o_s0_en,
                             bus.o_s1_en, bus.o_s0_wr_en, bus.o_s1_wr_en}), 64'(0));
    chk({name, "_rd_data"}, 64'(bus.o_rd_data), 64'(0));
    chk({name, "_addr"}, {bus.o_s0_addr, bus.o_s1_addr}, 64'(0));
    chk({name, "_wr_data"}, {bus.o_s0_wr_data, bus.o_s1_wr_data}, 64'(0));
    chk({name, "_byte_en"}, 64'({bus.o_s0_byte_en, bus.o_s1_byte_en}), 64'(0));
  endtask

  // Monitor: every upstream ack is matched against the oldest expected response.
  always @(negedge clk) begin
    if (!rst && bus.o_ack) begin
      if (sb.size() == 0) begin
        chk("ack_unexpected", 64'(bus.o_ack), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("ack_rd_data", 64'(bus.o_rd_data), 64'(e.rd));
        chk("ack_err", 64'(bus.o_err), 64'(e.err));
        chk("ack_cycle", 64'(cyc), 64'(e.at_edge));
      end
    end
  end

  task automatic drive_req(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                           input logic [3:0] be, input logic at, input logic id);
    bus.i_addr    = addr;
    bus.i_wr_en   = wr;
    bus.i_wr_data = wd;
    bus.i_byte_en = be;
    bus.i_atomic  = at;
    bus.i_id      = id;
    bus.i_bus_en  = 1'b1;
  endtask

  task automatic clear_inputs();
    bus.i_bus_en     = 1'b0;
    bus.i_wr_en      = 1'b0;
    bus.i_wr_data    = '0;
    bus.i_addr       = '0;
    bus.i_byte_en    = '0;
    bus.i_atomic     = 1'b0;
    bus.i_id         = 1'b0;
    bus.i_s0_ack     = 1'b0;
    bus.i_s0_rd_data = '0;
    bus.i_s1_ack     = 1'b0;
    bus.i_s1_rd_data = '0;
  endtask

  // k counts cycles after the request edge N; an ack raised at k is sampled at edge N+k+1.
  task automatic run_txn(input string name, input logic [31:0] addr, input logic wr,
                         input logic [31:0] wd, input logic [3:0] be, input logic at,
                         input logic id, input int sel, input int ack_s, input int ack_k,
                         input logic [31:0] srd, input logic [31:0] exp_rd, input logic exp_err,
                         input int exp_off, input int ncyc, input int exp_c0, input int exp_c1);
    int n;
    int c0;
    int c1;
    c0 = 0;
    c1 = 0;
    @(negedge clk);
    drive_req(addr, wr, wd, be, at, id);
    n = cyc + 1;
    sb.push_back('{exp_rd, exp_err, n + exp_off});
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (bus.o_s0_en) c0++;
      if (bus.o_s1_en) c1++;
      if (k == 0) begin
        bus.i_bus_en = 1'b0;
        if (sel == 0)
          chk({name, "_s0_fields"}, {bus.o_s0_wr_en, bus.o_s0_byte_en, bus.o_s0_addr[26:0], bus.o_s0_wr_data},
              {wr, be, addr[26:0], wd});
        if (sel == 1)
          chk({name, "_s1_fields"}, {bus.o_s1_wr_en, bus.o_s1_byte_en, bus.o_s1_addr[26:0], bus.o_s1_wr_data},
              {wr, be, addr[26:0], wd});
        if (sel >= 0)
          chk({name, "_atomic_id"}, 64'({bus.o_atomic, bus.o_id}), 64'({at, id}));
      end
      bus.i_s0_ack     = (ack_s == 0 && k == ack_k);
      bus.i_s0_rd_data = (ack_s == 0 && k == ack_k) ? srd : 32'h0;
      bus.i_s1_ack     = (ack_s == 1 && k == ack_k);
      bus.i_s1_rd_data = (ack_s == 1 && k == ack_k) ? srd : 32'h0;
    end
    clear_inputs();
    chk({name, "_s0_en_cycles"}, 64'(c0), 64'(exp_c0));
    chk({name, "_s1_en_cycles"}, 64'(c1), 64'(exp_c1));
  endtask

  initial begin
    int n;
    int c0;
    clear_inputs();
    #2;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_txn("mem_read", 32'h0000_0010, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0, 0, 0, 2,
            32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3, 7, 3, 0);
    run_txn("per_write", 32'h8000_0004, 1'b1, 32'h1234_5678, 4'b0011, 1'b0, 1'b1, 1, 1, 1,
            32'hFFFF_FFFF, 32'h0, 1'b0, 2, 6, 0, 2);
    run_txn("unmapped", 32'h4000_0000, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0, -1, -1, 0,
            32'h0, 32'h0, 1'b1, 0, 4, 0, 0);
    run_txn("timeout", 32'h0000_0100, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 0, 1, 3,
            32'h5555_5555, 32'h0, 1'b1, 17, 21, 17, 0);
    run_txn("ack_vs_timeout", 32'h0000_0200, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0, 0, 0, 16,
            32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 17, 21, 17, 0);
    run_txn("mem_top_min_rt", 32'h0000_FFFC, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1, 0, 0, 0,
            32'h0102_0304, 32'h0102_0304, 1'b0, 1, 5, 1, 0);
    run_txn("per_top", 32'h8000_0FFC, 1'b0, 32'h0, 4'hF, 1'b1, 1'b1, 1, 1, 0,
            32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 1, 5, 0, 1);
    run_txn("mem_past_end", 32'h0001_0000, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0, -1, -1, 0,
            32'h0, 32'h0, 1'b1, 0, 4, 0, 0);
    run_txn("per_past_end", 32'h8000_1000, 1'b1, 32'h0, 4'hF, 1'b0, 1'b0, -1, -1, 0,
            32'h0, 32'h0, 1'b1, 0, 4, 0, 0);

    // i_bus_en held through RESP and GAP: second request accepted at edge N+4.
    @(negedge clk);
    drive_req(32'h0000_0020, 1'b0, 32'h0, 4'hF, 1'b1, 1'b1);
    n = cyc + 1;
    c0 = 0;
    sb.push_back('{32'h1111_1111, 1'b0, n + 1});
    sb.push_back('{32'h2222_2222, 1'b0, n + 5});
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.o_s0_en) c0++;
      if (k == 0 || k == 4)
        chk("held_access_id_atomic_en", 64'({bus.o_s0_en, bus.o_atomic, bus.o_id}), 64'(3'b111));
      if (k == 3) chk("held_gap_ignored", 64'(bus.o_s0_en), 64'(0));
      if (k == 4) bus.i_bus_en = 1'b0;
      bus.i_s0_ack     = (k == 0 || k == 4);
      bus.i_s0_rd_data = (k == 0) ? 32'h1111_1111 : (k == 4) ? 32'h2222_2222 : 32'h0;
    end
    clear_inputs();
    chk("held_s0_en_cycles", 64'(c0), 64'(2));

    // Asynchronous reset in the middle of ACCESS aborts without a response.
    @(negedge clk);
    drive_req(32'h0000_0040, 1'b0, 32'h0, 4'hF, 1'b1, 1'b1);
    @(negedge clk);
    bus.i_bus_en = 1'b0;
    @(negedge clk);
    chk("pre_reset_s0_en", 64'(bus.o_s0_en), 64'(1));
    #1 rst = 1'b1;
    #1 check_zero("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_txn("post_reset_read", 32'h0000_0000, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0, 0, 0, 1,
            32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 2, 6, 2, 0);

    repeat (5) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
